// File: rtl/scratchpad_portb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scratchpad_portb_arbiter: round-robin/locked-burst arbiter for Port B,     |
// | with registered issue and per-requester read-data return.  Rev 1.0         |
// +----------------------------------------------------------------------------+
module scratchpad_portb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           sp_en_b,
  output logic                           sp_we_b,
  output logic [ADDR_WIDTH-1:0]          sp_addr_b,
  output logic [DATA_WIDTH-1:0]          sp_din_b,
  input  logic [DATA_WIDTH-1:0]          sp_dout_b
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [ID_W-1:0]         owner_q, owner_d;
  logic                    sp_en_q, sp_en_d;
  logic                    sp_we_q, sp_we_d;
  logic [ADDR_WIDTH-1:0]   sp_addr_q, sp_addr_d;
  logic [DATA_WIDTH-1:0]   sp_din_q, sp_din_d;
  logic [ID_W-1:0]         iss_id_q, iss_id_d;
  logic [RD_LATENCY-1:0]            rd_vld_q, rd_vld_d;
  logic [RD_LATENCY-1:0][ID_W-1:0]  rd_id_q, rd_id_d;

  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
  logic                    grant_vld;
  logic [ID_W-1:0]         grant_idx;
  logic [ID_W:0]           cand;
  logic [ID_W-1:0]         grant_nxt;
  logic                    accept;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Rotating search starting at the pointer; a locked owner bypasses the search.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (state_q == ST_LOCKED) begin
      grant_vld = req_valid[owner_q];
      grant_idx = owner_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = {1'b0, ptr_q} + (ID_W+1)'(k);
        if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
        if (!grant_vld && req_valid[cand[ID_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = cand[ID_W-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld && rst_n) req_ready[grant_idx] = 1'b1;
  end

  assign accept    = |req_ready;
  assign grant_nxt = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (accept) begin
      case (state_q)
        ST_ARB: begin
          ptr_d = grant_nxt;
          if (req_lock[grant_idx]) begin
            owner_d = grant_idx;
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (!req_lock[grant_idx]) begin
            ptr_d   = grant_nxt;
            state_d = ST_ARB;
          end
        end
        default: state_d = ST_ARB;
      endcase
    end
  end

  always_comb begin
    sp_en_d   = accept;
    sp_we_d   = accept & req_we[grant_idx];
    sp_addr_d = accept ? addr_arr[grant_idx]  : sp_addr_q;
    sp_din_d  = accept ? wdata_arr[grant_idx] : sp_din_q;
    iss_id_d  = accept ? grant_idx : iss_id_q;
  end

  // Tag pipeline starts at the issue cycle so its tail lines up with sp_dout_b.
  always_comb begin
    rd_vld_d    = '0;
    rd_id_d     = rd_id_q;
    rd_vld_d[0] = sp_en_q & ~sp_we_q;
    rd_id_d[0]  = iss_id_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_id_d[i]  = rd_id_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ARB;
      ptr_q     <= '0;
      owner_q   <= '0;
      sp_en_q   <= 1'b0;
      sp_we_q   <= 1'b0;
      sp_addr_q <= '0;
      sp_din_q  <= '0;
      iss_id_q  <= '0;
      rd_vld_q  <= '0;
      rd_id_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      sp_en_q   <= sp_en_d;
      sp_we_q   <= sp_we_d;
      sp_addr_q <= sp_addr_d;
      sp_din_q  <= sp_din_d;
      iss_id_q  <= iss_id_d;
      rd_vld_q  <= rd_vld_d;
      rd_id_q   <= rd_id_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (rd_vld_q[RD_LATENCY-1]) rsp_valid[rd_id_q[RD_LATENCY-1]] = 1'b1;
  end

  assign rsp_data  = sp_dout_b;
  assign sp_en_b   = sp_en_q;
  assign sp_we_b   = sp_we_q;
  assign sp_addr_b = sp_addr_q;
  assign sp_din_b  = sp_din_q;

endmodule
`default_nettype wire

// File: tb/tb_scratchpad_portb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_scratchpad_portb_arbiter: directed checks of arbitration, locking,      |
// | issue timing and read return at RD_LATENCY 1 and 3.  Rev 1.0               |
// +----------------------------------------------------------------------------+
module tb_scratchpad_portb_arbiter;
  localparam int NR = 4;
  localparam int AW = 13;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NR-1:0] req_valid, req_we, req_lock;
  logic [AW-1:0] a  [NR];
  logic [DW-1:0] wd [NR];
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  assign req_addr  = {a[3], a[2], a[1], a[0]};
  assign req_wdata = {wd[3], wd[2], wd[1], wd[0]};

  logic [NR-1:0] ready1, rspv1, ready3, rspv3;
  logic [DW-1:0] rspd1, din1, dout1, rspd3, din3, dout3;
  logic          en1, we1, en3, we3;
  logic [AW-1:0] addr1, addr3;

  scratchpad_portb_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready1), .req_we(req_we),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv1),
    .rsp_data(rspd1), .sp_en_b(en1), .sp_we_b(we1), .sp_addr_b(addr1), .sp_din_b(din1),
    .sp_dout_b(dout1));

  scratchpad_portb_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready3), .req_we(req_we),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv3),
    .rsp_data(rspd3), .sp_en_b(en3), .sp_we_b(we3), .sp_addr_b(addr3), .sp_din_b(din3),
    .sp_dout_b(dout3));

  // Scratchpad models: latency 1 and latency 3
  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] mem3 [0:(1<<AW)-1];
  logic [DW-1:0] d3a, d3b;

  always @(posedge clk) begin
    if (en1) begin
      if (we1) mem1[addr1] <= din1;
      else     dout1 <= mem1[addr1];
    end
  end

  always @(posedge clk) begin
    if (en3) begin
      if (we3) mem3[addr3] <= din3;
      else     d3a <= mem3[addr3];
    end
    d3b   <= d3a;
    dout3 <= d3b;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr_req();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      a[i]  = '0;
      wd[i] = '0;
    end
    mem1[13'h010] = 32'hDEADBEEF;
    mem3[13'h010] = 32'hDEADBEEF;
    mem1[13'h050] = 32'hCAFEF00D;
    mem3[13'h050] = 32'hCAFEF00D;

    // Reset state, with every requester asserting valid
    rst_n = 1'b0;
    clr_req();
    req_valid = 4'hF;
    step();
    step();
    check("rst_ready", 32'(ready1), 32'h0);
    check("rst_en", 32'(en1), 32'h0);
    check("rst_we", 32'(we1), 32'h0);
    check("rst_addr", 32'(addr1), 32'h0);
    check("rst_din", din1, 32'h0);
    check("rst_rspv", 32'(rspv1), 32'h0);
    clr_req();
    rst_n = 1'b1;

    // Single read by req0
    step();
    a[0] = 13'h010;
    req_valid = 4'b0001;
    #1 check("t1_ready", 32'(ready1), 32'h1);
    step();
    clr_req();
    #1;
    check("t1_en", 32'(en1), 32'h1);
    check("t1_addr", 32'(addr1), 32'h010);
    check("t1_we", 32'(we1), 32'h0);
    check("t1_rspv_early", 32'(rspv1), 32'h0);
    step();
    check("t1_rspv", 32'(rspv1), 32'h1);
    check("t1_rspd", rspd1, 32'hDEADBEEF);
    step();
    check("t1_rspv_once", 32'(rspv1), 32'h0);
    step();
    check("t1_l3_rspv", 32'(rspv3), 32'h1);
    check("t1_l3_rspd", rspd3, 32'hDEADBEEF);

    // All four requesters write continuously
    do_reset();
    for (int i = 0; i < NR; i++) begin
      a[i]  = 13'(13'h020 + i);
      wd[i] = 32'h1000 + 32'(i);
    end
    req_we    = 4'hF;
    req_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      #1 check("t2_ready", 32'(ready1), 32'(1 << (c % 4)));
      if (c > 0) begin
        check("t2_en", 32'(en1), 32'h1);
        check("t2_addr", 32'(addr1), 32'h20 + 32'((c - 1) % 4));
      end
      step();
    end
    clr_req();
    #1;
    check("t2_en_last", 32'(en1), 32'h1);
    check("t2_addr_last", 32'(addr1), 32'h20);
    check("t2_din_last", din1, 32'h1000);
    check("t2_we_last", 32'(we1), 32'h1);
    step();
    check("t2_en_idle", 32'(en1), 32'h0);
    check("t2_we_idle", 32'(we1), 32'h0);
    check("t2_addr_hold", 32'(addr1), 32'h20);

    // Locked burst from req1 with req2 waiting (pointer now at 1)
    a[2] = 13'h040;
    req_we = 4'b0010;
    req_valid = 4'b0110;
    for (int b = 0; b < 4; b++) begin
      a[1]  = 13'(13'h030 + b);
      wd[1] = 32'h2000 + 32'(b);
      req_lock[1] = (b < 3);
      if (b == 2) begin
        req_valid[1] = 1'b0;
        #1 check("t3_lock_hold", 32'(ready1), 32'h0);
        step();
        req_valid[1] = 1'b1;
      end
      #1 check("t3_burst_ready", 32'(ready1), 32'h2);
      step();
      check("t3_burst_addr", 32'(addr1), 32'h30 + 32'(b));
    end
    req_valid[1] = 1'b0;
    req_lock = '0;
    #1 check("t3_req2_ready", 32'(ready1), 32'h4);
    step();
    clr_req();
    #1;
    check("t3_req2_en", 32'(en1), 32'h1);
    check("t3_req2_addr", 32'(addr1), 32'h040);

    // Write by req2 then read of the same word by req3
    a[2] = 13'h100;
    wd[2] = 32'h00001234;
    req_we = 4'b0100;
    req_valid = 4'b0100;
    #1 check("t4_wr_ready", 32'(ready1), 32'h4);
    step();
    req_we = '0;
    a[3] = 13'h100;
    req_valid = 4'b1000;
    #1 check("t4_rd_ready", 32'(ready1), 32'h8);
    step();
    clr_req();
    step();
    check("t4_rspv", 32'(rspv1), 32'h8);
    check("t4_rspd", rspd1, 32'h00001234);

    // Reset while a read is in flight
    a[1] = 13'h010;
    req_valid = 4'b0010;
    #1 check("t5_ready", 32'(ready1), 32'h2);
    step();
    clr_req();
    rst_n = 1'b0;
    #1;
    check("t5_rst_en", 32'(en1), 32'h0);
    check("t5_rst_rspv", 32'(rspv1), 32'h0);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("t5_no_rsp1", 32'(rspv1), 32'h0);
      check("t5_no_rsp3", 32'(rspv3), 32'h0);
      step();
    end
    req_valid = 4'hF;
    #1 check("t5_first_grant", 32'(ready1), 32'h1);
    step();
    clr_req();

    // Back-to-back reads by req0 and req2 at both latencies
    do_reset();
    a[0] = 13'h010;
    a[2] = 13'h050;
    req_valid = 4'b0101;
    #1 check("t6_ready0", 32'(ready3), 32'h1);
    step();
    req_valid[0] = 1'b0;
    #1 check("t6_ready2", 32'(ready3), 32'h4);
    step();
    clr_req();
    #1;
    check("t6_l3_wait_a", 32'(rspv3), 32'h0);
    check("t6_l1_rspv0", 32'(rspv1), 32'h1);
    check("t6_l1_rspd0", rspd1, 32'hDEADBEEF);
    step();
    check("t6_l3_wait_b", 32'(rspv3), 32'h0);
    check("t6_l1_rspv2", 32'(rspv1), 32'h4);
    check("t6_l1_rspd2", rspd1, 32'hCAFEF00D);
    step();
    check("t6_l3_rspv0", 32'(rspv3), 32'h1);
    check("t6_l3_rspd0", rspd3, 32'hDEADBEEF);
    step();
    check("t6_l3_rspv2", 32'(rspv3), 32'h4);
    check("t6_l3_rspd2", rspd3, 32'hCAFEF00D);
    step();
    check("t6_l3_done", 32'(rspv3), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
